ysyx_24110006_lsu: RTL and testbench

YSYX_24110006_LSU -- requirements
Module: ysyx_24110006_lsu

---
 rtl/ysyx_24110006_pkg.sv | 34 +++
 rtl/ysyx_24110006_lsu_align.sv | 36 +++
 rtl/ysyx_24110006_lsu.sv | 193 +++++++++++++++++++
 tb/tb_ysyx_24110006_lsu.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24110006_pkg.sv
// Shared LSU definitions: FSM state encoding, load-type codes,
// exception cause codes and the misalignment helpers used at beat accept.
package ysyx_24110006_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RADDR = 3'd1,
    S_RDATA = 3'd2,
    S_WREQ  = 3'd3,
    S_WRESP = 3'd4,
    S_DONE  = 3'd5
  } lsu_state_e;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  localparam logic [3:0] MCAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] MCAUSE_LD_FAULT    = 4'd5;
  localparam logic [3:0] MCAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] MCAUSE_ST_FAULT    = 4'd7;

  // Halfword loads (LH/LHU share read_t[1:0]=01) need an even offset, words need offset 0.
  function automatic logic ld_misaligned(input logic [2:0] read_t, input logic [1:0] off);
    return ((read_t[1:0] == 2'b01) && off[0]) || ((read_t[1:0] == 2'b10) && (off != 2'b00));
  endfunction

  function automatic logic st_misaligned(input logic [3:0] wmask, input logic [1:0] off);
    return ((wmask == 4'b0011) && off[0]) || ((wmask == 4'b1111) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/ysyx_24110006_lsu_align.sv
// Combinational lane steering for the LSU.
//   i_off     : byte offset within the word (addr[1:0])
//   i_read_t  : load type; i_rdata : raw bus word -> o_ldata extracted/extended
//   i_wdata/i_wmask : unshifted store data/mask -> o_wdata/o_wstrb placed on lanes
module ysyx_24110006_lsu_align
  import ysyx_24110006_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_read_t,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wmask,
  output logic [31:0] o_ldata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb
);

  // Move the addressed lane down to bit 0; sub-word loads then just extend.
  logic [31:0] w_shift;
  assign w_shift = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_ldata = i_rdata;
    case (i_read_t)
      LD_LB:   o_ldata = {{24{w_shift[7]}}, w_shift[7:0]};
      LD_LH:   o_ldata = {{16{w_shift[15]}}, w_shift[15:0]};
      LD_LBU:  o_ldata = {24'h0, w_shift[7:0]};
      LD_LHU:  o_ldata = {16'h0, w_shift[15:0]};
      default: o_ldata = i_rdata;
    endcase
  end

  assign o_wdata = i_wdata << {i_off, 3'b000};
  assign o_wstrb = i_wmask << i_off;

endmodule

// File: rtl/ysyx_24110006_lsu.sv
// Load/store unit between execute and writeback.
//   i_valid/o_ready : beat in from execute (accepted only in IDLE)
//   o_valid/i_ready : beat out to writeback (o_wb_data, o_pc, o_reg_rd, o_reg_wen,
//                     o_exception, o_mcause)
//   AR/R, AW/W/B    : AXI-lite style memory channels, word-aligned addresses
module ysyx_24110006_lsu
  import ysyx_24110006_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_mem_ren,
  input  logic        i_mem_wen,
  input  logic [2:0]  i_mem_read_t,
  input  logic [3:0]  i_mem_wmask,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  input  logic [31:0] i_result,
  input  logic [31:0] i_pc,
  input  logic [4:0]  i_reg_rd,
  input  logic        i_reg_wen,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_wb_data,
  output logic [31:0] o_pc,
  output logic [4:0]  o_reg_rd,
  output logic        o_reg_wen,
  output logic        o_exception,
  output logic [3:0]  o_mcause,
  output logic [31:0] o_araddr,
  output logic        o_arvalid,
  input  logic        i_arready,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rresp,
  input  logic        i_rvalid,
  output logic        o_rready,
  output logic [31:0] o_awaddr,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic        o_awvalid,
  output logic        o_wvalid,
  input  logic        i_awready,
  input  logic        i_wready,
  input  logic [1:0]  i_bresp,
  input  logic        i_bvalid,
  output logic        o_bready
);

  lsu_state_e r_state, w_next;

  logic [31:0] r_addr, r_wdata, r_pc, r_wb_data;
  logic [2:0]  r_read_t;
  logic [3:0]  r_wmask, r_mcause;
  logic [4:0]  r_rd;
  logic        r_reg_wen, r_exc;
  // AW and W may complete on different cycles; remember which one is done.
  logic        r_aw_done, r_w_done;

  logic        w_ld_mis, w_st_mis;
  logic [31:0] w_ldata;

  assign w_ld_mis = ld_misaligned(i_mem_read_t, i_mem_addr[1:0]);
  assign w_st_mis = st_misaligned(i_mem_wmask, i_mem_addr[1:0]);

  ysyx_24110006_lsu_align u_align (
    .i_off    (r_addr[1:0]),
    .i_read_t (r_read_t),
    .i_rdata  (i_rdata),
    .i_wdata  (r_wdata),
    .i_wmask  (r_wmask),
    .o_ldata  (w_ldata),
    .o_wdata  (o_wdata),
    .o_wstrb  (o_wstrb)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    o_ready   = 1'b0;
    o_arvalid = 1'b0;
    o_rready  = 1'b0;
    o_awvalid = 1'b0;
    o_wvalid  = 1'b0;
    o_bready  = 1'b0;
    o_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        // ren wins over wen, so an illegal ren+wen beat runs as a load.
        if (i_valid) begin
          if (i_mem_ren)      w_next = w_ld_mis ? S_DONE : S_RADDR;
          else if (i_mem_wen) w_next = w_st_mis ? S_DONE : S_WREQ;
          else                w_next = S_DONE;
        end
      end
      S_RADDR: begin
        o_arvalid = 1'b1;
        if (i_arready) w_next = S_RDATA;
      end
      S_RDATA: begin
        o_rready = 1'b1;
        if (i_rvalid) w_next = S_DONE;
      end
      S_WREQ: begin
        o_awvalid = ~r_aw_done;
        o_wvalid  = ~r_w_done;
        if ((r_aw_done | i_awready) && (r_w_done | i_wready)) w_next = S_WRESP;
      end
      S_WRESP: begin
        o_bready = 1'b1;
        if (i_bvalid) w_next = S_DONE;
      end
      S_DONE: begin
        o_valid = 1'b1;
        if (i_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_pc      <= '0;
      r_wb_data <= '0;
      r_read_t  <= '0;
      r_wmask   <= '0;
      r_mcause  <= '0;
      r_rd      <= '0;
      r_reg_wen <= 1'b0;
      r_exc     <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_valid) begin
          r_addr    <= i_mem_addr;
          r_wdata   <= i_mem_wdata;
          r_pc      <= i_pc;
          r_wb_data <= i_result;  // replaced by load data when the R beat lands
          r_read_t  <= i_mem_read_t;
          r_wmask   <= i_mem_wmask;
          r_rd      <= i_reg_rd;
          r_reg_wen <= i_reg_wen;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          r_exc     <= 1'b0;
          r_mcause  <= 4'd0;
          if (i_mem_ren && w_ld_mis) begin
            r_exc    <= 1'b1;
            r_mcause <= MCAUSE_LD_MISALIGN;
          end else if (!i_mem_ren && i_mem_wen && w_st_mis) begin
            r_exc    <= 1'b1;
            r_mcause <= MCAUSE_ST_MISALIGN;
          end
        end
        S_RDATA: if (i_rvalid) begin
          r_wb_data <= w_ldata;
          if (i_rresp != 2'b00) begin
            r_exc     <= 1'b1;
            r_mcause  <= MCAUSE_LD_FAULT;
            r_reg_wen <= 1'b0;
          end
        end
        S_WREQ: begin
          if (i_awready) r_aw_done <= 1'b1;
          if (i_wready)  r_w_done  <= 1'b1;
        end
        S_WRESP: if (i_bvalid && (i_bresp != 2'b00)) begin
          r_exc    <= 1'b1;
          r_mcause <= MCAUSE_ST_FAULT;
        end
        default: ;
      endcase
    end
  end

  assign o_araddr    = {r_addr[31:2], 2'b00};
  assign o_awaddr    = {r_addr[31:2], 2'b00};
  assign o_wb_data   = r_wb_data;
  assign o_pc        = r_pc;
  assign o_reg_rd    = r_rd;
  assign o_reg_wen   = r_reg_wen;
  assign o_exception = r_exc;
  assign o_mcause    = r_mcause;

endmodule

// File: tb/tb_ysyx_24110006_lsu.sv
// Randomized + directed bench for the LSU with a behavioural bus slave and
// a reference model of the expected writeback beat.
module tb_ysyx_24110006_lsu;

  logic        clk = 1'b0, rst;
  logic        i_valid, o_ready, i_mem_ren, i_mem_wen, i_reg_wen;
  logic [2:0]  i_mem_read_t;
  logic [3:0]  i_mem_wmask;
  logic [31:0] i_mem_addr, i_mem_wdata, i_result, i_pc;
  logic [4:0]  i_reg_rd;
  logic        o_valid, i_ready, o_reg_wen, o_exception;
  logic [31:0] o_wb_data, o_pc;
  logic [4:0]  o_reg_rd;
  logic [3:0]  o_mcause;
  logic [31:0] o_araddr, i_rdata, o_awaddr, o_wdata;
  logic        o_arvalid, i_arready, i_rvalid, o_rready;
  logic [1:0]  i_rresp, i_bresp;
  logic [3:0]  o_wstrb;
  logic        o_awvalid, o_wvalid, i_awready, i_wready, i_bvalid, o_bready;

  always #5 clk = ~clk;

  ysyx_24110006_lsu dut (
    .i_clock(clk), .i_reset(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_mem_ren(i_mem_ren), .i_mem_wen(i_mem_wen), .i_mem_read_t(i_mem_read_t),
    .i_mem_wmask(i_mem_wmask), .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata),
    .i_result(i_result), .i_pc(i_pc), .i_reg_rd(i_reg_rd), .i_reg_wen(i_reg_wen),
    .o_valid(o_valid), .i_ready(i_ready), .o_wb_data(o_wb_data), .o_pc(o_pc),
    .o_reg_rd(o_reg_rd), .o_reg_wen(o_reg_wen), .o_exception(o_exception),
    .o_mcause(o_mcause), .o_araddr(o_araddr), .o_arvalid(o_arvalid),
    .i_arready(i_arready), .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid),
    .o_rready(o_rready), .o_awaddr(o_awaddr), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
    .o_awvalid(o_awvalid), .o_wvalid(o_wvalid), .i_awready(i_awready),
    .i_wready(i_wready), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready)
  );

  typedef struct {
    logic        ren, wen, rwen;
    logic [2:0]  rt;
    logic [3:0]  wmask;
    logic [31:0] addr, wdata, result, pc, rdata;
    logic [4:0]  rd;
    logic [1:0]  rresp, bresp;
    int          ar_dly, r_dly, aw_dly, w_dly, b_dly, done_dly;
  } beat_t;

  int n_vec = 0, n_err = 0;

  // Values seen on the last beat, for directed constant checks.
  logic [31:0] obs_wb, obs_wdata, obs_mcause, obs_exc, obs_reg_wen;
  logic [31:0] obs_wstrb;
  int          obs_lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] rt, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int          off;
    logic [7:0]  bt [4];
    logic [7:0]  b;
    logic [15:0] h;
    off = int'(addr & 32'd3);
    for (int i = 0; i < 4; i++) bt[i] = rdata[8*i +: 8];
    b = bt[off];
    h = {bt[(off + 1) % 4], bt[off]};
    case (rt)
      3'b000:  return 32'($signed(b));
      3'b001:  return 32'($signed(h));
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return rdata;
    endcase
  endfunction

  task automatic run_beat(input beat_t b);
    logic        is_ld, is_st, mis, seen, hold_ok;
    int          off, lat, exp_lat, mx;
    int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    int          ar_hs, r_hs, aw_hs, w_hs, b_hs, drops, early_b;
    logic        p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
    logic [31:0] p_araddr, p_awaddr, p_wdata, ar_addr, aw_addr, exp_wb;
    logic [3:0]  p_wstrb, exp_mc;
    logic        exp_exc;

    is_ld = b.ren;
    is_st = b.wen && !b.ren;
    off   = int'(b.addr & 32'd3);
    mis   = 1'b0;
    if (is_ld && (b.rt == 3'b001 || b.rt == 3'b101)) mis = (off % 2) == 1;
    if (is_ld && b.rt == 3'b010)                     mis = off != 0;
    if (is_st && b.wmask == 4'b0011)                 mis = (off % 2) == 1;
    if (is_st && b.wmask == 4'b1111)                 mis = off != 0;

    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0; drops = 0; early_b = 0;
    p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
    p_araddr = 0; p_awaddr = 0; p_wdata = 0; p_wstrb = 0;
    ar_addr = 0; aw_addr = 0; obs_wdata = 0; obs_wstrb = 0;

    check("ready_idle", 32'(o_ready), 32'd1);
    i_valid = 1'b1; i_mem_ren = b.ren; i_mem_wen = b.wen; i_mem_read_t = b.rt;
    i_mem_wmask = b.wmask; i_mem_addr = b.addr; i_mem_wdata = b.wdata;
    i_result = b.result; i_pc = b.pc; i_reg_rd = b.rd; i_reg_wen = b.rwen;
    @(negedge clk);
    i_valid = 1'b0; i_mem_addr = $urandom; i_result = $urandom; i_pc = $urandom;

    lat = 1; seen = 1'b0;
    for (int s = 0; s < 80 && !seen; s++) begin
      if (p_arv && !p_arr && (!o_arvalid || o_araddr !== p_araddr)) drops++;
      if (p_awv && !p_awr && (!o_awvalid || o_awaddr !== p_awaddr)) drops++;
      if (p_wv && !p_wr && (!o_wvalid || o_wdata !== p_wdata || o_wstrb !== p_wstrb)) drops++;
      if (o_bready && !(aw_hs == 1 && w_hs == 1)) early_b++;
      if (o_valid) begin
        seen = 1'b1; obs_lat = lat;
        i_arready = 0; i_rvalid = 0; i_awready = 0; i_wready = 0; i_bvalid = 0;
      end else begin
        i_arready = o_arvalid && (ar_cnt >= b.ar_dly);
        if (o_arvalid) ar_cnt++;
        if (o_arvalid && i_arready) begin ar_hs++; ar_addr = o_araddr; end
        i_rvalid = o_rready && (r_cnt >= b.r_dly);
        i_rdata  = i_rvalid ? b.rdata : $urandom;
        i_rresp  = i_rvalid ? b.rresp : 2'b00;
        if (o_rready) r_cnt++;
        if (o_rready && i_rvalid) r_hs++;
        i_awready = o_awvalid && (aw_cnt >= b.aw_dly);
        if (o_awvalid) aw_cnt++;
        if (o_awvalid && i_awready) begin aw_hs++; aw_addr = o_awaddr; end
        i_wready = o_wvalid && (w_cnt >= b.w_dly);
        if (o_wvalid) w_cnt++;
        if (o_wvalid && i_wready) begin w_hs++; obs_wdata = o_wdata; obs_wstrb = 32'(o_wstrb); end
        i_bvalid = o_bready && (b_cnt >= b.b_dly);
        i_bresp  = i_bvalid ? b.bresp : 2'b00;
        if (o_bready) b_cnt++;
        if (o_bready && i_bvalid) b_hs++;
        p_arv = o_arvalid; p_arr = i_arready; p_araddr = o_araddr;
        p_awv = o_awvalid; p_awr = i_awready; p_awaddr = o_awaddr;
        p_wv = o_wvalid; p_wr = i_wready; p_wdata = o_wdata; p_wstrb = o_wstrb;
        @(negedge clk);
        lat++;
      end
    end
    check("timeout", 32'(seen), 32'd1);

    mx = (b.aw_dly > b.w_dly) ? b.aw_dly : b.w_dly;
    if (mis || (!is_ld && !is_st)) exp_lat = 1;
    else if (is_ld)                exp_lat = 3 + b.ar_dly + b.r_dly;
    else                           exp_lat = 3 + mx + b.b_dly;

    exp_exc = 1'b0; exp_mc = 4'd0;
    if (mis)                                  begin exp_exc = 1; exp_mc = is_ld ? 4'd4 : 4'd6; end
    else if (is_ld && b.rresp != 2'b00)       begin exp_exc = 1; exp_mc = 4'd5; end
    else if (is_st && b.bresp != 2'b00)       begin exp_exc = 1; exp_mc = 4'd7; end
    exp_wb = (is_ld && !mis) ? ref_load(b.rt, b.addr, b.rdata) : b.result;

    obs_wb = o_wb_data; obs_mcause = 32'(o_mcause); obs_exc = 32'(o_exception);
    obs_reg_wen = 32'(o_reg_wen);

    check("latency", 32'(obs_lat), 32'(exp_lat));
    if (!(is_ld && mis)) check("wb_data", o_wb_data, exp_wb);
    check("pc", o_pc, b.pc);
    check("reg_rd", 32'(o_reg_rd), 32'(b.rd));
    check("reg_wen", 32'(o_reg_wen), 32'(b.rwen && !(is_ld && !mis && b.rresp != 2'b00)));
    check("exception", 32'(o_exception), 32'(exp_exc));
    check("mcause", 32'(o_mcause), 32'(exp_mc));
    check("ar_hs", 32'(ar_hs), 32'((is_ld && !mis) ? 1 : 0));
    check("r_hs", 32'(r_hs), 32'((is_ld && !mis) ? 1 : 0));
    check("aw_hs", 32'(aw_hs), 32'((is_st && !mis) ? 1 : 0));
    check("w_hs", 32'(w_hs), 32'((is_st && !mis) ? 1 : 0));
    check("b_hs", 32'(b_hs), 32'((is_st && !mis) ? 1 : 0));
    check("valid_drop", 32'(drops), 32'd0);
    check("early_bready", 32'(early_b), 32'd0);
    if (is_ld && !mis) check("araddr", ar_addr, b.addr & 32'hFFFF_FFFC);
    if (is_st && !mis) begin
      check("awaddr", aw_addr, b.addr & 32'hFFFF_FFFC);
      check("wdata", obs_wdata, b.wdata << (8 * off));
      check("wstrb", obs_wstrb, 32'(4'(b.wmask << off)));
    end

    hold_ok = 1'b1;
    repeat (b.done_dly) begin
      @(negedge clk);
      if (!o_valid) hold_ok = 1'b0;
    end
    check("valid_hold", 32'(hold_ok), 32'd1);
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    check("valid_clear", 32'(o_valid), 32'd0);
    check("ready_back", 32'(o_ready), 32'd1);
  endtask

  function automatic beat_t base_beat();
    beat_t b;
    b.ren = 0; b.wen = 0; b.rwen = 1; b.rt = 3'b010; b.wmask = 4'b1111;
    b.addr = 32'h8000_0000; b.wdata = 0; b.result = 0; b.pc = 32'h8000_1000;
    b.rdata = 0; b.rd = 5'd1; b.rresp = 0; b.bresp = 0;
    b.ar_dly = 0; b.r_dly = 0; b.aw_dly = 0; b.w_dly = 0; b.b_dly = 0; b.done_dly = 0;
    return b;
  endfunction

  function automatic beat_t rand_beat();
    beat_t        b;
    int           k;
    logic [2:0]   rts [5];
    logic [3:0]   wms [3];
    rts[0] = 3'b000; rts[1] = 3'b001; rts[2] = 3'b010; rts[3] = 3'b100; rts[4] = 3'b101;
    wms[0] = 4'b0001; wms[1] = 4'b0011; wms[2] = 4'b1111;
    b = base_beat();
    k = $urandom_range(0, 9);
    b.ren = (k >= 3 && k <= 5) || k == 9;
    b.wen = (k >= 6);
    b.rt = rts[$urandom_range(0, 4)];
    b.wmask = wms[$urandom_range(0, 2)];
    b.addr = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
    if ($urandom_range(0, 3) != 0) begin
      if (b.ren && b.rt[1:0] == 2'b10) b.addr[1:0] = 2'b00;
      if (b.ren && b.rt[1:0] == 2'b01) b.addr[0] = 1'b0;
      if (!b.ren && b.wmask == 4'b1111) b.addr[1:0] = 2'b00;
      if (!b.ren && b.wmask == 4'b0011) b.addr[0] = 1'b0;
    end
    b.wdata = $urandom; b.result = $urandom; b.pc = $urandom; b.rdata = $urandom;
    b.rd = 5'($urandom); b.rwen = 1'($urandom);
    b.rresp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    b.bresp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    b.ar_dly = $urandom_range(0, 3); b.r_dly = $urandom_range(0, 3);
    b.aw_dly = $urandom_range(0, 3); b.w_dly = $urandom_range(0, 3);
    b.b_dly = $urandom_range(0, 3); b.done_dly = $urandom_range(0, 2);
    return b;
  endfunction

  initial begin
    beat_t b;
    logic  got_rdata;
    rst = 1'b1; i_valid = 0; i_mem_ren = 0; i_mem_wen = 0; i_mem_read_t = 0;
    i_mem_wmask = 0; i_mem_addr = 0; i_mem_wdata = 0; i_result = 0; i_pc = 0;
    i_reg_rd = 0; i_reg_wen = 0; i_ready = 0; i_arready = 0; i_rdata = 0;
    i_rresp = 0; i_rvalid = 0; i_awready = 0; i_wready = 0; i_bresp = 0; i_bvalid = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_bus", 32'({o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready}), 32'd0);
    check("rst_exc", 32'(o_exception), 32'd0);
    check("rst_mcause", 32'(o_mcause), 32'd0);

    // LB from the top byte lane, sign-extended.
    b = base_beat(); b.ren = 1; b.rt = 3'b000; b.addr = 32'h8000_0003; b.rdata = 32'h80FF_0000;
    run_beat(b);
    check("lb_wb", obs_wb, 32'hFFFF_FF80);
    check("lb_lat", 32'(obs_lat), 32'd3);

    // SH into the upper halfword.
    b = base_beat(); b.wen = 1; b.wmask = 4'b0011; b.addr = 32'h8000_0002; b.wdata = 32'h0000_1234;
    run_beat(b);
    check("sh_wdata", obs_wdata, 32'h1234_0000);
    check("sh_wstrb", obs_wstrb, 32'b1100);

    // AW accepted two cycles before W.
    b = base_beat(); b.wen = 1; b.addr = 32'h8000_0010; b.wdata = 32'hDEAD_BEEF;
    b.aw_dly = 0; b.w_dly = 2;
    run_beat(b);
    check("split_lat", 32'(obs_lat), 32'd5);

    // Load bus error.
    b = base_beat(); b.ren = 1; b.addr = 32'h8000_0020; b.rresp = 2'b10; b.rwen = 1;
    run_beat(b);
    check("rresp_exc", obs_exc, 32'd1);
    check("rresp_mcause", obs_mcause, 32'd5);
    check("rresp_regwen", obs_reg_wen, 32'd0);

    // Misaligned LW never touches the bus.
    b = base_beat(); b.ren = 1; b.rt = 3'b010; b.addr = 32'h8000_0001;
    run_beat(b);
    check("mis_mcause", obs_mcause, 32'd4);
    check("mis_lat", 32'(obs_lat), 32'd1);

    // Reset while waiting in RDATA, then an ALU beat.
    i_valid = 1; i_mem_ren = 1; i_mem_wen = 0; i_mem_read_t = 3'b010;
    i_mem_addr = 32'h8000_0040; i_reg_wen = 1;
    @(negedge clk);
    i_valid = 0;
    got_rdata = 1'b0;
    for (int s = 0; s < 10 && !got_rdata; s++) begin
      if (o_rready) got_rdata = 1'b1;
      else begin
        i_arready = o_arvalid;
        @(negedge clk);
      end
    end
    i_arready = 0;
    check("rst_mid_reach", 32'(got_rdata), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_rready", 32'(o_rready), 32'd0);
    check("rst_mid_ready", 32'(o_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    b = base_beat(); b.result = 32'h55; b.rwen = 1;
    run_beat(b);
    check("alu_after_rst", obs_wb, 32'h55);

    for (int n = 0; n < 250; n++) run_beat(rand_beat());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
